// File: rtl/commit_unit_pkg.sv
// Shared core constants and pointer types for the retirement stage.
// No logic; sizes here are the defaults the core is built with.
// Types are sized from these defaults for use by surrounding blocks.
package commit_unit_pkg;

  localparam int AL_SIZE        = 32;
  localparam int PHYS_REG_NUM   = 64;
  localparam int FREE_LIST_SIZE = 32;
  localparam int LQ_SIZE        = 8;
  localparam int SQ_SIZE        = 8;
  localparam int BR_NUM         = 4;

  localparam int AL_W = $clog2(AL_SIZE);
  localparam int P_W  = $clog2(PHYS_REG_NUM);
  localparam int FL_W = $clog2(FREE_LIST_SIZE);
  localparam int LQ_W = $clog2(LQ_SIZE);
  localparam int SQ_W = $clog2(SQ_SIZE);
  localparam int BR_W = $clog2(BR_NUM);

  typedef logic [AL_W-1:0] al_ptr_t;
  typedef logic [P_W-1:0]  preg_t;
  typedef logic [FL_W-1:0] fl_ptr_t;
  typedef logic [LQ_W-1:0] lq_ptr_t;
  typedef logic [SQ_W-1:0] sq_ptr_t;
  typedef logic [BR_W-1:0] br_ptr_t;

  // Increment that sticks at all-ones instead of rolling over.
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/commit_unit_wrap_ptr.sv
// Modulo-N ring pointer (N power of 2) with optional wrap-parity bit.
// Latency: pointer advances at the posedge following inc_i.
// Backpressure: none; the owner decides when to increment.
module wrap_ptr #(
  parameter int  N         = 8,
  parameter bit  HAS_COLOR = 1'b0,
  localparam int W         = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc_i,
  output logic [W-1:0] ptr_o,
  output logic         color_o
);

  logic [W-1:0] ptr_q, ptr_d;
  logic         color_q, color_d;

  // Next pointer; parity flips only when stepping from N-1 back to 0.
  always_comb begin
    ptr_d   = ptr_q;
    color_d = color_q;
    if (inc_i) begin
      ptr_d = ptr_q + 1'b1;
      if (HAS_COLOR && (ptr_q == W'(N - 1))) begin
        color_d = ~color_q;
      end
    end
  end

  // Pointer and parity state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q   <= '0;
      color_q <= 1'b0;
    end else begin
      ptr_q   <= ptr_d;
      color_q <= color_d;
    end
  end

  assign ptr_o   = ptr_q;
  assign color_o = color_q;

endmodule

// File: rtl/commit_unit.sv
// In-order retirement of the active-list head plus commit-pointer bookkeeping.
// Latency: retire decision and pulses combinational; pointers move next posedge.
// Backpressure: branch_miss or store_stall (store at head) hold retirement.
module commit_unit #(
  parameter int  AL_SIZE        = commit_unit_pkg::AL_SIZE,
  parameter int  PHYS_REG_NUM   = commit_unit_pkg::PHYS_REG_NUM,
  parameter int  FREE_LIST_SIZE = commit_unit_pkg::FREE_LIST_SIZE,
  parameter int  LQ_SIZE        = commit_unit_pkg::LQ_SIZE,
  parameter int  SQ_SIZE        = commit_unit_pkg::SQ_SIZE,
  parameter int  BR_NUM         = commit_unit_pkg::BR_NUM,
  localparam int AL_W           = $clog2(AL_SIZE),
  localparam int P_W            = $clog2(PHYS_REG_NUM),
  localparam int FL_W           = $clog2(FREE_LIST_SIZE),
  localparam int LQ_W           = $clog2(LQ_SIZE),
  localparam int SQ_W           = $clog2(SQ_SIZE),
  localparam int BR_W           = $clog2(BR_NUM)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [AL_SIZE-1:0]            ready_to_commit,
  input  logic [AL_SIZE-1:0]            is_load,
  input  logic [AL_SIZE-1:0]            is_store,
  input  logic [AL_SIZE-1:0]            is_branch,
  input  logic [AL_SIZE-1:0]            uses_rw,
  input  logic [AL_SIZE-1:0][P_W-1:0]   reclaim_list,
  input  logic [AL_W-1:0]               youngest_inst_pointer,
  input  logic                          global_color_bit,
  input  logic                          branch_miss,
  input  logic                          store_stall,
  output logic                          commit_valid,
  output logic [AL_W-1:0]               commit_id,
  output logic                          branch_done,
  output logic                          load_done,
  output logic                          store_done,
  output logic                          reclaim_valid,
  output logic [P_W-1:0]                reclaim_preg,
  output logic [AL_W-1:0]               oldest_inst_pointer,
  output logic [FL_W-1:0]               free_tail_pointer,
  output logic [LQ_W-1:0]               load_commit_pointer,
  output logic [SQ_W-1:0]               store_commit_pointer,
  output logic [BR_W-1:0]               branch_read_pointer,
  output logic                          al_empty,
  output logic [31:0]                   retired_count
);

  import commit_unit_pkg::sat_inc;

  logic        oldest_color;
  logic [3:0]  unused_color;   // only the head ring needs its wrap parity
  logic [31:0] retired_count_q, retired_count_d;

  // Head entry attributes and the retire decision, all from current pointers.
  always_comb begin
    al_empty      = (oldest_inst_pointer == youngest_inst_pointer) &&
                    (oldest_color == global_color_bit);
    commit_valid  = !al_empty && ready_to_commit[oldest_inst_pointer] && !branch_miss &&
                    !(is_store[oldest_inst_pointer] && store_stall);
    commit_id     = oldest_inst_pointer;
    store_done    = commit_valid && is_store[oldest_inst_pointer];
    // A doubly-flagged entry is treated as a store only.
    load_done     = commit_valid && is_load[oldest_inst_pointer] && !is_store[oldest_inst_pointer];
    branch_done   = commit_valid && is_branch[oldest_inst_pointer];
    reclaim_valid = commit_valid && uses_rw[oldest_inst_pointer];
    reclaim_preg  = reclaim_list[oldest_inst_pointer];
  end

  wrap_ptr #(.N(AL_SIZE), .HAS_COLOR(1'b1)) u_head (
    .clk(clk), .rst_n(rst_n), .inc_i(commit_valid),
    .ptr_o(oldest_inst_pointer), .color_o(oldest_color)
  );

  wrap_ptr #(.N(FREE_LIST_SIZE)) u_free_tail (
    .clk(clk), .rst_n(rst_n), .inc_i(reclaim_valid),
    .ptr_o(free_tail_pointer), .color_o(unused_color[0])
  );

  wrap_ptr #(.N(LQ_SIZE)) u_lq (
    .clk(clk), .rst_n(rst_n), .inc_i(load_done),
    .ptr_o(load_commit_pointer), .color_o(unused_color[1])
  );

  wrap_ptr #(.N(SQ_SIZE)) u_sq (
    .clk(clk), .rst_n(rst_n), .inc_i(store_done),
    .ptr_o(store_commit_pointer), .color_o(unused_color[2])
  );

  wrap_ptr #(.N(BR_NUM)) u_br (
    .clk(clk), .rst_n(rst_n), .inc_i(branch_done),
    .ptr_o(branch_read_pointer), .color_o(unused_color[3])
  );

  // Retired-instruction count, saturating rather than wrapping.
  always_comb begin
    retired_count_d = retired_count_q;
    if (commit_valid) begin
      retired_count_d = sat_inc(retired_count_q);
    end
  end

  // Retired-count register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      retired_count_q <= '0;
    end else begin
      retired_count_q <= retired_count_d;
    end
  end

  assign retired_count = retired_count_q;

endmodule

// File: tb/tb_commit_unit.sv
// Directed bench for commit_unit: expected retirements go into a scoreboard
// queue when stimulus is applied; a negedge monitor pops and compares them.
module tb_commit_unit;
  import commit_unit_pkg::*;

  logic clk;
  logic rst_n;
  logic [AL_SIZE-1:0] ready_to_commit, is_load, is_store, is_branch, uses_rw;
  preg_t [AL_SIZE-1:0] reclaim_list;
  al_ptr_t youngest_inst_pointer;
  logic global_color_bit, branch_miss, store_stall;

  logic    commit_valid, branch_done, load_done, store_done, reclaim_valid, al_empty;
  al_ptr_t commit_id, oldest_inst_pointer;
  preg_t   reclaim_preg;
  fl_ptr_t free_tail_pointer;
  lq_ptr_t load_commit_pointer;
  sq_ptr_t store_commit_pointer;
  br_ptr_t branch_read_pointer;
  logic [31:0] retired_count;

  commit_unit dut (
    .clk(clk), .rst_n(rst_n),
    .ready_to_commit(ready_to_commit), .is_load(is_load), .is_store(is_store),
    .is_branch(is_branch), .uses_rw(uses_rw), .reclaim_list(reclaim_list),
    .youngest_inst_pointer(youngest_inst_pointer), .global_color_bit(global_color_bit),
    .branch_miss(branch_miss), .store_stall(store_stall),
    .commit_valid(commit_valid), .commit_id(commit_id),
    .branch_done(branch_done), .load_done(load_done), .store_done(store_done),
    .reclaim_valid(reclaim_valid), .reclaim_preg(reclaim_preg),
    .oldest_inst_pointer(oldest_inst_pointer), .free_tail_pointer(free_tail_pointer),
    .load_commit_pointer(load_commit_pointer), .store_commit_pointer(store_commit_pointer),
    .branch_read_pointer(branch_read_pointer), .al_empty(al_empty),
    .retired_count(retired_count)
  );

  typedef struct packed {
    al_ptr_t id;
    logic    br;
    logic    ld;
    logic    st;
    logic    rv;
    preg_t   preg;
  } exp_t;

  exp_t sb_q[$];
  int   vectors = 0;
  int   miscompares = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic set_entry(input int idx, input logic rdy, input logic ld, input logic st,
                           input logic br, input logic rw, input preg_t preg);
    ready_to_commit[idx] = rdy;
    is_load[idx]         = ld;
    is_store[idx]        = st;
    is_branch[idx]       = br;
    uses_rw[idx]         = rw;
    reclaim_list[idx]    = preg;
  endtask

  task automatic expect_commit(input al_ptr_t id, input logic br, input logic ld,
                               input logic st, input logic rv, input preg_t preg);
    exp_t e;
    e.id = id; e.br = br; e.ld = ld; e.st = st; e.rv = rv; e.preg = preg;
    sb_q.push_back(e);
  endtask

  // Monitor: every retirement the DUT presents must match the oldest expectation.
  always @(negedge clk) begin
    if (commit_valid === 1'b1) begin
      if (sb_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL sb_unexpected: commit id %0d with nothing expected", commit_id);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        vectors++;
        if (commit_id !== e.id || branch_done !== e.br || load_done !== e.ld ||
            store_done !== e.st || reclaim_valid !== e.rv ||
            (e.rv && reclaim_preg !== e.preg)) begin
          miscompares++;
          $display("FAIL sb_commit: got id=%0d br=%b ld=%b st=%b rv=%b preg=%0d expected id=%0d br=%b ld=%b st=%b rv=%b preg=%0d",
                   commit_id, branch_done, load_done, store_done, reclaim_valid, reclaim_preg,
                   e.id, e.br, e.ld, e.st, e.rv, e.preg);
        end
      end
    end
  end

  initial begin
    #20000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    ready_to_commit = '0; is_load = '0; is_store = '0; is_branch = '0; uses_rw = '0;
    reclaim_list = '0;
    youngest_inst_pointer = '0; global_color_bit = 1'b0;
    branch_miss = 1'b0; store_stall = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_empty", al_empty, 1);
    chk("rst_head", oldest_inst_pointer, 0);
    chk("rst_cv", commit_valid, 0);
    chk("rst_count", retired_count, 0);

    // Single ALU retire with register reclaim
    @(posedge clk); #1;
    set_entry(0, 1, 0, 0, 0, 1, 6'd37);
    youngest_inst_pointer = 5'd1;
    expect_commit(5'd0, 0, 0, 0, 1, 6'd37);
    @(negedge clk);
    chk("alu_cv", commit_valid, 1);
    @(posedge clk); #1;
    ready_to_commit[0] = 1'b0;
    @(negedge clk);
    chk("alu_head", oldest_inst_pointer, 1);
    chk("alu_free", free_tail_pointer, 1);
    chk("alu_count", retired_count, 1);
    chk("alu_empty", al_empty, 1);

    // Back-to-back load, store, branch, ALU(no rw)
    @(posedge clk); #1;
    set_entry(1, 1, 1, 0, 0, 0, 6'd0);
    set_entry(2, 1, 0, 1, 0, 0, 6'd0);
    set_entry(3, 1, 0, 0, 1, 0, 6'd0);
    set_entry(4, 1, 0, 0, 0, 0, 6'd0);
    youngest_inst_pointer = 5'd5;
    expect_commit(5'd1, 0, 1, 0, 0, 6'd0);
    expect_commit(5'd2, 0, 0, 1, 0, 6'd0);
    expect_commit(5'd3, 1, 0, 0, 0, 6'd0);
    expect_commit(5'd4, 0, 0, 0, 0, 6'd0);
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("mix_head", oldest_inst_pointer, 5);
    chk("mix_lq", load_commit_pointer, 1);
    chk("mix_sq", store_commit_pointer, 1);
    chk("mix_br", branch_read_pointer, 1);
    chk("mix_free", free_tail_pointer, 1);
    chk("mix_count", retired_count, 5);

    // Store stalled for three cycles; entry also flagged load (store wins)
    @(posedge clk); #1;
    set_entry(5, 1, 1, 1, 0, 0, 6'd0);
    youngest_inst_pointer = 5'd6;
    store_stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("stall_cv", commit_valid, 0);
      chk("stall_head", oldest_inst_pointer, 5);
      @(posedge clk); #1;
    end
    store_stall = 1'b0;
    expect_commit(5'd5, 0, 0, 1, 0, 6'd0);
    @(negedge clk);
    chk("stall_release_cv", commit_valid, 1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("stall_head_after", oldest_inst_pointer, 6);
    chk("stall_sq", store_commit_pointer, 2);
    chk("stall_lq", load_commit_pointer, 1);
    chk("stall_count", retired_count, 6);

    // Drain 6..31 so the head wraps and its parity flips
    @(posedge clk); #1;
    for (int i = 6; i < AL_SIZE; i++) begin
      set_entry(i, 1, 0, 0, 0, 1, preg_t'(i));
      expect_commit(al_ptr_t'(i), 0, 0, 0, 1, preg_t'(i));
    end
    youngest_inst_pointer = 5'd0;
    global_color_bit = 1'b1;
    repeat (26) @(posedge clk);
    @(negedge clk);
    chk("wrap_head", oldest_inst_pointer, 0);
    chk("wrap_empty", al_empty, 1);
    chk("wrap_free", free_tail_pointer, 27);
    chk("wrap_count", retired_count, 32);

    // Full list (colors differ) with a coincident branch_miss
    @(posedge clk); #1;
    ready_to_commit = '0;
    set_entry(0, 1, 0, 0, 0, 1, 6'd12);
    global_color_bit = 1'b0;
    branch_miss = 1'b1;
    @(negedge clk);
    chk("full_not_empty", al_empty, 0);
    chk("miss_cv", commit_valid, 0);
    @(posedge clk); #1;
    branch_miss = 1'b0;
    expect_commit(5'd0, 0, 0, 0, 1, 6'd12);
    @(negedge clk);
    chk("miss_head_held", oldest_inst_pointer, 0);
    chk("miss_count_held", retired_count, 32);
    @(posedge clk); #1;
    ready_to_commit[0] = 1'b0;
    @(negedge clk);
    chk("full_head", oldest_inst_pointer, 1);
    chk("full_free", free_tail_pointer, 28);
    chk("full_count", retired_count, 33);

    // Asynchronous reset mid-stream, between clock edges
    @(posedge clk); #1;
    ready_to_commit = '1;
    expect_commit(5'd1, 0, 1, 0, 0, 6'd0);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    youngest_inst_pointer = 5'd0;
    global_color_bit = 1'b0;
    #1;
    chk("arst_head", oldest_inst_pointer, 0);
    chk("arst_count", retired_count, 0);
    chk("arst_free", free_tail_pointer, 0);
    chk("arst_lq", load_commit_pointer, 0);
    chk("arst_empty", al_empty, 1);
    chk("arst_cv", commit_valid, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_head", oldest_inst_pointer, 0);
    chk("post_rst_cv", commit_valid, 0);

    chk("sb_drained", sb_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/commit_unit.md
# commit_unit

In-order retirement stage of the out-of-order MIPS core; it sits directly upstream of the state-update register block. Each cycle it inspects the oldest active-list entry and, when that entry is complete, retires it. On retirement it emits the branch/load/store done pulses, the reclaimed physical register and the advanced commit pointers. The state-update block consumes these to free active-list, branch, load-queue and store-queue entries.

## Interface
Parameters:
- AL_SIZE, 32, active-list entries (power of 2); AL_W = $clog2(AL_SIZE)
- PHYS_REG_NUM, 64, physical registers; P_W = $clog2(PHYS_REG_NUM)
- FREE_LIST_SIZE, 32, free-list entries (power of 2)
- LQ_SIZE, 8, load-queue entries (power of 2)
- SQ_SIZE, 8, store-queue entries (power of 2)
- BR_NUM, 4, branch-state entries (power of 2)

Ports:
- clk  in  1  clock
- rst_n  in  1  reset; one clock, reset is asynchronous and active-low
- ready_to_commit  in  AL_SIZE  per-entry completion bits
- is_load / is_store / is_branch  in  AL_SIZE each  per-entry type flags
- uses_rw  in  AL_SIZE  entry writes a register
- reclaim_list  in  AL_SIZE×P_W  previous mapping to free on retire
- youngest_inst_pointer  in  AL_W  active-list tail
- global_color_bit  in  1  tail wrap parity
- branch_miss  in  1  misprediction recovery this cycle
- store_stall  in  1  D-cache cannot accept a committed store
- commit_valid  out  1  an entry retires this cycle
- commit_id  out  AL_W  retiring entry index (= oldest_inst_pointer)
- branch_done / load_done / store_done  out  1 each  typed retire pulses
- reclaim_valid  out  1  reclaim_preg is pushed to the free list
- reclaim_preg  out  P_W  freed physical register
- oldest_inst_pointer  out  AL_W  active-list head
- free_tail_pointer  out  $clog2(FREE_LIST_SIZE)  free-list write slot
- load_commit_pointer  out  $clog2(LQ_SIZE)
- store_commit_pointer  out  $clog2(SQ_SIZE)
- branch_read_pointer  out  $clog2(BR_NUM)
- al_empty  out  1  no in-flight entries
- retired_count  out  32  instructions retired since reset

## Operation
- State: oldest_inst_pointer, oldest_color, free_tail_pointer, load/store commit pointers, branch_read_pointer and retired_count.
- al_empty = (oldest_inst_pointer == youngest_inst_pointer) && (oldest_color == global_color_bit).
- h = oldest_inst_pointer. commit_valid = !al_empty && ready_to_commit[h] && !branch_miss && !(is_store[h] && store_stall).
- When commit_valid:
  - branch_done = is_branch[h], load_done = is_load[h], store_done = is_store[h].
  - reclaim_valid = uses_rw[h]; reclaim_preg = reclaim_list[h].
- Next-edge updates on commit:
  - head +1, with oldest_color toggled on wrap AL_SIZE-1→0.
  - free_tail_pointer +1 if reclaim_valid.
  - Each typed pointer +1 when its done pulse is set.
  - retired_count +1, saturating at 2^32-1.
- All pointers wrap modulo their queue size. The flags are exclusive per entry; if both load and store flags are set, store wins and load_done stays 0.
- branch_miss suppresses retirement for that cycle only and leaves all commit pointers unchanged. Recovery only trims entries younger than the branch, so the head is never invalidated.

## Timing
- The retire decision and the done/reclaim outputs are combinational from the current pointers and inputs. They always reference the pre-increment pointer values, so the consumer indexes with the current pointers in the same cycle.
- Pointers advance at the following posedge. Throughput is at most 1 retire per cycle, and back-to-back retires are allowed.
- Reset (asynchronous, any time, including mid-stream): all pointers 0, oldest_color 0, retired_count 0, all pulses 0. al_empty=1 follows provided the upstream tail/color also reset to 0.
- store_stall holds a ready store at the head for as many cycles as asserted, with no pulses emitted. The store retires in the first cycle store_stall is low.
- Full active list (pointers equal, colors differ): commits normally; not treated as empty.

## Structure
- The shared core package carries the AL_SIZE/PHYS_REG_NUM/FREE_LIST_SIZE/LQ_SIZE/SQ_SIZE/BR_NUM constants and the pointer typedefs (al_ptr_t, preg_t, lq_ptr_t, sq_ptr_t, br_ptr_t).
- One sub-module, wrap_ptr: a parameterised modulo counter with increment enable and optional wrap-parity output. It is instantiated for the head (with color) and for the four other pointers.

## Test plan
- Reset: release rst_n with tail=0, color=0 → al_empty=1, all pointers 0, no pulses.
- ALU retire: entry 0 ready, uses_rw=1, reclaim_list[0]=37, tail=1 → commit_valid, reclaim_preg=37; next cycle head=1, free_tail=1, retired_count=1.
- Mixed stream: entries 0..3 = load, store, branch, ALU(no rw), all ready → one pulse each in cycles 0..3; final LQ ptr=1, SQ ptr=1, BR ptr=1, free_tail unchanged.
- Store stall: store at head ready, store_stall high for 3 cycles → no commit for 3 cycles, store_done on the 4th; head advances once.
- Wrap: head=31 with color 0 retires → head=0, color=1; tail=0 with global_color=1 → al_empty=1.
- branch_miss coincident with a ready head → no retire that cycle; retires the next cycle with unchanged pointers. Asserting rst_n low mid-stream clears state immediately, without waiting for a clock edge.
